// File: rtl/result_serializer.sv
// Serializes a captured 4x4 matrix of 8-bit results into 16 ready/valid beats.
// Optional RESULT_SERIALIZER_TRANSPOSE_EN selects column-major beat order.
module result_serializer (
  input  logic                  i_clk,
  input  logic                  i_arst,
  input  logic [3:0][3:0][7:0]  i_c,
  input  logic                  i_validResult,
  output logic                  o_ready,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [7:0]            o_data,
  output logic [1:0]            o_row,
  output logic [1:0]            o_col,
  output logic                  o_last,
  output logic                  o_overrun
);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t               state;
  logic [3:0]           k;
  logic [3:0][3:0][7:0] cap;
  logic                 overrun_q;

  logic [1:0] row;
  logic [1:0] col;
  logic       xfer;
  logic       capture;

  always_comb begin
`ifdef RESULT_SERIALIZER_TRANSPOSE_EN
    row = k[1:0];
    col = k[3:2];
`else
    row = k[3:2];
    col = k[1:0];
`endif
  end

  assign o_valid = (state == STREAM);
  assign o_last  = o_valid && (k == 4'd15);
  assign xfer    = o_valid && i_ready;
  // Ready also opens during the last-beat transfer so a new matrix follows with no bubble.
  assign o_ready = !o_valid || (o_last && i_ready);
  assign capture = i_validResult && o_ready;

  assign o_data    = o_valid ? cap[row][col] : '0;
  assign o_row     = o_valid ? row : '0;
  assign o_col     = o_valid ? col : '0;
  assign o_overrun = overrun_q;

  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      state     <= IDLE;
      k         <= '0;
      cap       <= '0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= i_validResult && !o_ready;
      if (capture) begin
        cap   <= i_c;
        k     <= '0;
        state <= STREAM;
      end else if (xfer) begin
        if (o_last) begin
          state <= IDLE;
          k     <= '0;
        end else begin
          k <= k + 4'd1;
        end
      end
    end
  end

endmodule
